meas_sched: RTL and testbench

MEAS_SCHED -- requirements
Module: meas_sched

---
 rtl/meas_pkg.sv | 26 ++
 rtl/crc8_w16.sv | 22 ++
 rtl/meas_sched.sv | 156 +++++++++++++++
 tb/tb_meas_sched.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/meas_pkg.sv
// Shared definitions for the measurement scheduler: FSM encoding, CRC-8 constants, rx_data field layout.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package meas_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        CMD_W,
        CONV,
        RD,
        RD_W,
        CHECK,
        SETTLE
    } state_t;

    localparam logic [7:0] CRC_POLY = 8'h31;
    localparam logic [7:0] CRC_INIT = 8'hFF;

    // rx_data = {T[15:0], CRC_T[7:0], RH[15:0], CRC_RH[7:0]}
    localparam int RX_T_LSB     = 32;
    localparam int RX_CRCT_LSB  = 24;
    localparam int RX_RH_LSB    = 8;
    localparam int RX_CRCRH_LSB = 0;

endpackage

// File: rtl/crc8_w16.sv
// CRC-8 (poly 0x31, init 0xFF, MSB first, no reflection, no final XOR) over one 16-bit word.
// Latency: purely combinational.
// Backpressure: none.
module crc8_w16
    import meas_pkg::*;
(
    input  logic [15:0] data,
    output logic [7:0]  crc
);

    always_comb begin
        crc = CRC_INIT;
        for (int i = 15; i >= 0; i--) begin
            if (crc[7] ^ data[i]) begin
                crc = {crc[6:0], 1'b0} ^ CRC_POLY;
            end else begin
                crc = {crc[6:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/meas_sched.sv
// Periodic sensor measurement sequencer: command, conversion wait, 6-byte read, optional CRC check (CRC_CHECK_EN), result load.
// Latency: upd fires DP_LAT+1 cycles after temp_raw/hum_raw load; one measurement per PERIOD_CYC when idle.
// Backpressure: none; waits indefinitely on i2c_done, and period wraps seen while busy are dropped.
module meas_sched
    import meas_pkg::*;
#(
    parameter int PERIOD_CYC = 50_000_000,
    parameter int CONV_CYC   = 1_000_000,
    parameter int DP_LAT     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        i2c_req,
    output logic        i2c_rd,
    input  logic        i2c_done,
    input  logic        i2c_err,
    input  logic [47:0] rx_data,
    output logic [15:0] temp_raw,
    output logic [15:0] hum_raw,
    output logic        upd,
    output logic [7:0]  err_cnt
);

    localparam int PW   = $clog2(PERIOD_CYC + 1);
    localparam int TMAX = (CONV_CYC > DP_LAT + 1) ? CONV_CYC : DP_LAT + 1;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [PW-1:0] PER_LAST    = PW'(PERIOD_CYC - 1);
    localparam logic [TW-1:0] CONV_LAST   = TW'(CONV_CYC - 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(DP_LAT);

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] per_cnt;
    logic [TW-1:0] tmr;
    logic [47:0]   rx_q;
    logic          wrap;
    logic          pass;
    logic          cap;
    logic          load;
    logic          err_inc;

    assign wrap = en && (per_cnt == PER_LAST);

    always_ff @(posedge clk) begin
        if (rst || !en || wrap) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + 1'b1;
        end
    end

    // Dwell timer restarts on every state change; only CONV and SETTLE look at it.
    always_ff @(posedge clk) begin
        if (rst || (state_nxt != state)) begin
            tmr <= '0;
        end else if (state == CONV || state == SETTLE) begin
            tmr <= tmr + 1'b1;
        end
    end

`ifdef CRC_CHECK_EN
    logic [7:0] crc_t;
    logic [7:0] crc_rh;

    crc8_w16 u_crc_t (
        .data (rx_q[RX_T_LSB +: 16]),
        .crc  (crc_t)
    );

    crc8_w16 u_crc_rh (
        .data (rx_q[RX_RH_LSB +: 16]),
        .crc  (crc_rh)
    );

    assign pass = (crc_t == rx_q[RX_CRCT_LSB +: 8]) && (crc_rh == rx_q[RX_CRCRH_LSB +: 8]);
`else
    logic unused_crc_bytes;
    assign unused_crc_bytes = ^{rx_q[RX_CRCT_LSB +: 8], rx_q[RX_CRCRH_LSB +: 8]};
    assign pass = 1'b1;
`endif

    assign cap = (state == RD_W) && i2c_done && !i2c_err;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        err_inc   = 1'b0;
        case (state)
            IDLE:   if (wrap) state_nxt = CMD;
            CMD:    state_nxt = CMD_W;
            CMD_W: begin
                if (i2c_done) begin
                    if (i2c_err) begin
                        err_inc   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = CONV;
                    end
                end
            end
            CONV:   if (tmr == CONV_LAST) state_nxt = RD;
            RD:     state_nxt = RD_W;
            RD_W: begin
                if (i2c_done) begin
                    if (i2c_err) begin
                        err_inc   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = CHECK;
                    end
                end
            end
            CHECK: begin
                if (pass) begin
                    load      = 1'b1;
                    state_nxt = SETTLE;
                end else begin
                    err_inc   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            SETTLE: if (tmr == SETTLE_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pulses are decoded from state and forced low while rst is held.
    assign i2c_req = !rst && (state == CMD || state == RD);
    assign i2c_rd  = !rst && (state == RD);
    assign upd     = !rst && (state == SETTLE) && (tmr == SETTLE_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rx_q     <= '0;
            temp_raw <= '0;
            hum_raw  <= '0;
            err_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (cap) begin
                rx_q <= rx_data;
            end
            if (load) begin
                temp_raw <= rx_q[RX_T_LSB +: 16];
                hum_raw  <= rx_q[RX_RH_LSB +: 16];
            end
            if (err_inc && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_meas_sched.sv
// Directed + randomized bench for meas_sched; the sensor side is played by tasks, results predicted by a transaction-level model.
module tb_meas_sched;

    localparam int PERIOD = 100;
    localparam int CONV   = 10;
    localparam int DPL    = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        i2c_req;
    logic        i2c_rd;
    logic        i2c_done;
    logic        i2c_err;
    logic [47:0] rx_data;
    logic [15:0] temp_raw;
    logic [15:0] hum_raw;
    logic        upd;
    logic [7:0]  err_cnt;

    int          tests = 0;
    int          fails = 0;

    // reference model state
    int          exp_err = 0;
    logic [15:0] exp_t   = '0;
    logic [15:0] exp_h   = '0;

    meas_sched #(
        .PERIOD_CYC (PERIOD),
        .CONV_CYC   (CONV),
        .DP_LAT     (DPL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .i2c_req  (i2c_req),
        .i2c_rd   (i2c_rd),
        .i2c_done (i2c_done),
        .i2c_err  (i2c_err),
        .rx_data  (rx_data),
        .temp_raw (temp_raw),
        .hum_raw  (hum_raw),
        .upd      (upd),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Byte-oriented CRC-8 as the sensor computes it: two bytes, MSB first.
    function automatic logic [7:0] crc8(input logic [15:0] w);
        logic [7:0] c;
        c = 8'hFF;
        for (int b = 1; b >= 0; b--) begin
            c = c ^ w[b*8 +: 8];
            for (int k = 0; k < 8; k++) begin
                c = c[7] ? ((c << 1) ^ 8'h31) : (c << 1);
            end
        end
        return c;
    endfunction

    function automatic int sat_inc(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_temp"}, temp_raw, exp_t);
        chk({tag, "_hum"},  hum_raw,  exp_h);
        chk({tag, "_err"},  err_cnt,  exp_err);
    endtask

    // One complete measurement as seen from the sensor side.
    task automatic do_meas(input bit cmd_err, input bit rd_err,
                           input logic [15:0] t, input logic [15:0] h,
                           input logic [7:0] flip_t, input logic [7:0] flip_h,
                           input bit drop_en);
        int  k;
        int  nupd;
        int  pos;
        bit  seen;
        bit  pass;

        k = 0;
        while (!i2c_req && k < PERIOD + 5) begin
            tick();
            k++;
        end
        chk("cmd_req", i2c_req, 1);
        chk("cmd_kind", i2c_rd, 0);
        tick();
        chk("cmd_pulse_len", i2c_req, 0);
        repeat ($urandom_range(0, 4)) tick();
        i2c_done = 1'b1;
        i2c_err  = cmd_err;
        tick();
        i2c_done = 1'b0;
        i2c_err  = 1'b0;

        if (cmd_err) begin
            exp_err = sat_inc(exp_err);
            seen = 1'b0;
            nupd = 0;
            repeat (CONV + 8) begin
                if (i2c_req) seen = 1'b1;
                if (upd) nupd++;
                tick();
            end
            chk("cmd_err_no_rd", seen, 0);
            chk("cmd_err_no_upd", nupd, 0);
            chk_outputs("cmd_err");
            return;
        end

        // read request lands CONV cycles of conversion after the command completes
        k = 1;
        while (!i2c_req && k < CONV + 10) begin
            tick();
            k++;
        end
        chk("conv_len", k, CONV + 1);
        chk("rd_kind", i2c_rd, 1);
        tick();
        chk("rd_pulse_len", i2c_req, 0);
        if (drop_en) en = 1'b0;

        repeat ($urandom_range(0, 4)) tick();
        rx_data  = {t, crc8(t) ^ flip_t, h, crc8(h) ^ flip_h};
        i2c_done = 1'b1;
        i2c_err  = rd_err;
        tick();
        i2c_done = 1'b0;
        i2c_err  = 1'b0;
        rx_data  = {16'($urandom), 32'($urandom)};

        if (rd_err) begin
            exp_err = sat_inc(exp_err);
            nupd = 0;
            repeat (DPL + 8) begin
                if (upd) nupd++;
                tick();
            end
            chk("rd_err_no_upd", nupd, 0);
            chk_outputs("rd_err");
            return;
        end

`ifdef CRC_CHECK_EN
        pass = (flip_t == 8'h00) && (flip_h == 8'h00);
`else
        pass = 1'b1;
`endif
        tick();
        if (pass) begin
            exp_t = t;
            exp_h = h;
        end else begin
            exp_err = sat_inc(exp_err);
        end
        chk_outputs("check");

        // load edge -> upd sampled DP_LAT+1 edges later, i.e. DPL negedges after this point
        nupd = 0;
        pos  = -1;
        for (int i = 0; i < DPL + 6; i++) begin
            if (upd) begin
                nupd++;
                pos = i;
            end
            tick();
        end
        chk("upd_count", nupd, pass ? 1 : 0);
        if (pass) chk("upd_pos", pos, DPL);
        chk_outputs("settled");
    endtask

    initial begin
        int k;
        int nreq;
        int nupd;
        logic [7:0] fl;

        rst      = 1'b1;
        en       = 1'b0;
        i2c_done = 1'b0;
        i2c_err  = 1'b0;
        rx_data  = '0;
        repeat (3) tick();
        chk("rst_req", i2c_req, 0);
        chk("rst_rd", i2c_rd, 0);
        chk("rst_upd", upd, 0);
        chk_outputs("rst");

        rst = 1'b0;
        en  = 1'b1;
        k = 0;
        while (!i2c_req && k < 2 * PERIOD) begin
            tick();
            k++;
        end
        chk("first_period", k, PERIOD);

        // nominal measurement with the datasheet example word
        do_meas(1'b0, 1'b0, 16'h6666, 16'h8000, 8'h00, 8'h00, 1'b0);

        // NACK on the command
        do_meas(1'b1, 1'b0, 16'h1234, 16'h5678, 8'h00, 8'h00, 1'b0);

        // stray completions in IDLE are ignored
        i2c_done = 1'b1;
        i2c_err  = 1'b1;
        tick();
        i2c_done = 1'b0;
        i2c_err  = 1'b0;
        tick();
        chk("stray_done_err", err_cnt, exp_err);
        chk("stray_done_req", i2c_req, 0);

        // corrupted humidity CRC
        do_meas(1'b0, 1'b0, 16'h4321, 16'hA5C3, 8'h00, 8'h01, 1'b0);

        // en drops during RD_W: measurement completes, then silence
        do_meas(1'b0, 1'b0, 16'h0F0F, 16'h7E81, 8'h00, 8'h00, 1'b1);
        nreq = 0;
        repeat (2 * PERIOD + 10) begin
            if (i2c_req) nreq++;
            tick();
        end
        chk("en_low_no_req", nreq, 0);
        en = 1'b1;

        // reset pulse during CONV
        k = 0;
        while (!i2c_req && k < PERIOD + 5) begin
            tick();
            k++;
        end
        chk("pre_rst_cmd", i2c_req, 1);
        tick();
        i2c_done = 1'b1;
        tick();
        i2c_done = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_t   = '0;
        exp_h   = '0;
        exp_err = 0;
        chk("conv_rst_req", i2c_req, 0);
        chk("conv_rst_upd", upd, 0);
        chk_outputs("conv_rst");
        k = 0;
        nupd = 0;
        while (!i2c_req && k < 2 * PERIOD) begin
            if (upd) nupd++;
            tick();
            k++;
        end
        chk("post_rst_period", k, PERIOD);
        chk("post_rst_no_upd", nupd, 0);

        // randomized measurements
        for (int n = 0; n < 24; n++) begin
            fl = 8'(1 << $urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0:       do_meas(1'b1, 1'b0, 16'($urandom), 16'($urandom), 8'h00, 8'h00, 1'b0);
                1:       do_meas(1'b0, 1'b1, 16'($urandom), 16'($urandom), 8'h00, 8'h00, 1'b0);
                2:       do_meas(1'b0, 1'b0, 16'($urandom), 16'($urandom), fl, 8'h00, 1'b0);
                3:       do_meas(1'b0, 1'b0, 16'($urandom), 16'($urandom), 8'h00, fl, 1'b0);
                default: do_meas(1'b0, 1'b0, 16'($urandom), 16'($urandom), 8'h00, 8'h00, 1'b0);
            endcase
        end

        // saturation of the failure counter
        for (int n = 0; n < 300; n++) begin
            do_meas(($urandom_range(0, 1) == 0), 1'b1, 16'($urandom), 16'($urandom), 8'h00, 8'h00, 1'b0);
        end
        chk("err_saturated", err_cnt, 8'hFF);
        do_meas(1'b0, 1'b0, 16'hBEEF, 16'h0102, 8'h00, 8'h00, 1'b0);
        chk("err_held", err_cnt, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
